// File: rtl/mct_pkg.sv
// Shared types and helpers for the multi-channel timer bank.
package mct_pkg;

    typedef enum logic [1:0] {
        MODE_OFF      = 2'b00,
        MODE_PERIODIC = 2'b01,
        MODE_ONESHOT  = 2'b10
    } mode_t;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    // The unused encoding 2'b11 behaves exactly like OFF.
    function automatic logic mode_active(input logic [1:0] m);
        return (m == MODE_PERIODIC) || (m == MODE_ONESHOT);
    endfunction

endpackage

// File: rtl/mct_channel.sv
// One timer channel: shadow config, IDLE/RUN FSM, up-counter and tick decode.
module mct_channel
    import mct_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we_i,
    input  logic [WIDTH-1:0] cfg_period_i,
    input  logic [1:0]       cfg_mode_i,
    input  logic             start_i,
    output logic             tick_o,
    output logic             busy_o,
    output logic [WIDTH-1:0] count_o
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic [WIDTH-1:0] shadow_period_q, shadow_period_d;
    logic [1:0]       shadow_mode_q, shadow_mode_d;
    logic             terminal;

    // Terminal cycle and status come only from registered state.
    assign terminal = (state_q == ST_RUN) && (count_q == active_q);
    assign tick_o   = terminal;
    assign busy_o   = (state_q == ST_RUN);
    assign count_o  = count_q;

    // Next-state: shadow writes, start/restart, off-write abort, reload or stop at terminal.
    always_comb begin
        state_d         = state_q;
        count_d         = count_q;
        active_d        = active_q;
        shadow_period_d = shadow_period_q;
        shadow_mode_d   = shadow_mode_q;

        if (cfg_we_i) begin
            shadow_period_d = cfg_period_i;
            shadow_mode_d   = cfg_mode_i;
        end

        case (state_q)
            ST_IDLE: begin
                // Start always sees the shadow values from before any same-cycle write.
                if (start_i && mode_active(shadow_mode_q)) begin
                    state_d  = ST_RUN;
                    count_d  = '0;
                    active_d = shadow_period_q;
                end
            end
            ST_RUN: begin
                if (start_i) begin
                    count_d  = '0;
                    active_d = shadow_period_q;
                end else if (cfg_we_i && !mode_active(cfg_mode_i)) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end else if (terminal) begin
                    count_d = '0;
                    if (shadow_mode_q == MODE_PERIODIC) begin
                        active_d = shadow_period_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
    end

    // Channel state registers, all cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            count_q         <= '0;
            active_q        <= '0;
            shadow_period_q <= '0;
            shadow_mode_q   <= MODE_OFF;
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            active_q        <= active_d;
            shadow_period_q <= shadow_period_d;
            shadow_mode_q   <= shadow_mode_d;
        end
    end

endmodule

// File: rtl/multi_channel_timer.sv
// Bank of independent programmable timers with a registered count readback.
module multi_channel_timer
    import mct_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [WIDTH-1:0]    cfg_period,
    input  logic [1:0]          cfg_mode,
    input  logic [CHANNELS-1:0] start,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] busy,
    input  logic [CH_W-1:0]     rd_ch,
    output logic [WIDTH-1:0]    rd_count
);

    logic [CHANNELS-1:0][WIDTH-1:0] count_all;
    logic [WIDTH-1:0]               rd_count_q, rd_count_d;

    // Addresses at or beyond CHANNELS match no channel, so those writes are dropped.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic we;
        assign we = cfg_we && (cfg_ch == CH_W'(i));

        mct_channel #(.WIDTH(WIDTH)) u_ch (
            .clk          (clk),
            .rst          (rst),
            .cfg_we_i     (we),
            .cfg_period_i (cfg_period),
            .cfg_mode_i   (cfg_mode),
            .start_i      (start[i]),
            .tick_o       (tick[i]),
            .busy_o       (busy[i]),
            .count_o      (count_all[i])
        );
    end

    // Readback mux; an out-of-range select reads as zero.
    always_comb begin
        rd_count_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (rd_ch == CH_W'(i)) begin
                rd_count_d = count_all[i];
            end
        end
    end

    // Readback register gives one cycle of latency from rd_ch.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count_q <= '0;
        end else begin
            rd_count_q <= rd_count_d;
        end
    end

    assign rd_count = rd_count_q;

endmodule

// File: tb/tb_multi_channel_timer.sv
// Scoreboard bench for multi_channel_timer: expected tick cycles are queued by
// the stimulus thread and consumed by an independent tick monitor.
module tb_multi_channel_timer;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int CH_W     = 2;

    logic                clk;
    logic                rst;
    logic                cfg_we;
    logic [CH_W-1:0]     cfg_ch;
    logic [WIDTH-1:0]    cfg_period;
    logic [1:0]          cfg_mode;
    logic [CHANNELS-1:0] start;
    logic [CHANNELS-1:0] tick;
    logic [CHANNELS-1:0] busy;
    logic [CH_W-1:0]     rd_ch;
    logic [WIDTH-1:0]    rd_count;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int exp_q [CHANNELS][$];
    int mon_e;

    multi_channel_timer #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_mode   (cfg_mode),
        .start      (start),
        .tick       (tick),
        .busy       (busy),
        .rd_ch      (rd_ch),
        .rd_count   (rd_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle index: value k holds between posedge k and posedge k+1.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic fail_event(input string name, input int act, input int exp_v);
        n_chk++;
        n_err++;
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    endtask

    // Tick monitor: every tick must match the head of its channel queue.
    always @(negedge clk) begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            if (tick[ch]) begin
                if (exp_q[ch].size() == 0) begin
                    fail_event($sformatf("unexpected_tick_ch%0d", ch), cyc, -1);
                end else begin
                    mon_e = exp_q[ch].pop_front();
                    chk($sformatf("tick_cycle_ch%0d", ch), cyc, mon_e);
                end
            end else if (exp_q[ch].size() > 0 && exp_q[ch][0] <= cyc) begin
                mon_e = exp_q[ch].pop_front();
                fail_event($sformatf("missing_tick_ch%0d", ch), -1, mon_e);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) next_cycle();
    endtask

    task automatic cfg_write(input int ch, input int p, input logic [1:0] m);
        cfg_we     = 1'b1;
        cfg_ch     = CH_W'(ch);
        cfg_period = WIDTH'(p);
        cfg_mode   = m;
        next_cycle();
        cfg_we     = 1'b0;
    endtask

    task automatic pulse_start(input logic [CHANNELS-1:0] mask);
        start = mask;
        next_cycle();
        start = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0;
        cfg_mode = 2'b00; start = '0; rd_ch = '0;

        // Reset state, then a start with every channel still OFF.
        goto(3);
        chk("reset_tick", int'(tick), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_rd_count", int'(rd_count), 0);
        rst = 1'b0;
        goto(4);
        pulse_start(4'hF);
        goto(6);
        chk("off_start_ignored_busy", int'(busy), 0);

        // ch0 P=4 periodic, then P=1 written mid-count, then stopped.
        goto(7);
        cfg_write(0, 4, 2'b01);
        goto(10);
        pulse_start(4'b0001);
        exp_q[0].push_back(15); exp_q[0].push_back(20); exp_q[0].push_back(25);
        exp_q[0].push_back(27); exp_q[0].push_back(29); exp_q[0].push_back(31);
        chk("ch0_busy_rise", int'(busy[0]), 1);
        goto(14);
        chk("ch0_rd_count", int'(rd_count), 2);
        goto(18);
        chk("ch0_busy_hold", int'(busy[0]), 1);
        goto(22);
        cfg_write(0, 1, 2'b01);
        goto(24);
        chk("ch0_busy_after_rewrite", int'(busy[0]), 1);
        goto(32);
        cfg_write(0, 0, 2'b00);
        chk("ch0_off_busy", int'(busy[0]), 0);

        // ch1 P=2 one-shot.
        goto(35);
        cfg_write(1, 2, 2'b10);
        goto(37);
        pulse_start(4'b0010);
        exp_q[1].push_back(40);
        goto(40);
        chk("ch1_busy_at_tick", int'(busy[1]), 1);
        goto(41);
        chk("ch1_busy_drop", int'(busy[1]), 0);

        // ch2 P=3 one-shot restarted in its terminal cycle.
        goto(48);
        cfg_write(2, 3, 2'b10);
        goto(50);
        pulse_start(4'b0100);
        exp_q[2].push_back(54);
        goto(52);
        rd_ch = 2'd2;
        goto(54);
        pulse_start(4'b0100);
        exp_q[2].push_back(58);
        chk("ch2_restart_busy", int'(busy[2]), 1);
        goto(57);
        chk("ch2_restart_count", int'(rd_count), 1);
        goto(59);
        chk("ch2_oneshot_idle", int'(busy[2]), 0);

        // ch3: config write and start in the same cycle.
        goto(62);
        cfg_write(3, 2, 2'b01);
        goto(64);
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_period = 8'd6; cfg_mode = 2'b01;
        pulse_start(4'b1000);
        cfg_we = 1'b0;
        exp_q[3].push_back(67); exp_q[3].push_back(74);
        goto(76);
        cfg_write(3, 0, 2'b00);
        chk("ch3_off_busy", int'(busy[3]), 0);

        // ch0 P=0 periodic ticks every cycle until switched off.
        goto(80);
        cfg_write(0, 0, 2'b01);
        goto(82);
        pulse_start(4'b0001);
        for (int t = 83; t <= 88; t++) exp_q[0].push_back(t);
        goto(88);
        cfg_write(0, 0, 2'b00);
        chk("ch0_p0_off_busy", int'(busy[0]), 0);
        chk("ch0_p0_off_tick", int'(tick[0]), 0);

        // Full-range ch1 plus ch2/ch3 running, then reset mid-flight.
        goto(90);
        cfg_write(1, 255, 2'b01);
        cfg_write(2, 5, 2'b01);
        cfg_write(3, 7, 2'b01);
        goto(93);
        rd_ch = 2'd1;
        pulse_start(4'b1110);
        exp_q[1].push_back(349);
        for (int t = 99; t < 405; t += 6) exp_q[2].push_back(t);
        for (int t = 101; t < 405; t += 8) exp_q[3].push_back(t);
        goto(200);
        chk("all_busy", int'(busy), 14);
        goto(349);
        chk("full_range_rd_254", int'(rd_count), 254);
        goto(350);
        chk("full_range_rd_255", int'(rd_count), 255);
        goto(351);
        chk("full_range_rd_wrap0", int'(rd_count), 0);
        goto(404);
        rst = 1'b1;
        next_cycle();
        chk("midrst_tick", int'(tick), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_rd_count", int'(rd_count), 0);
        goto(406);
        rst = 1'b0;
        goto(407);
        pulse_start(4'hF);
        goto(409);
        chk("post_rst_off_start_busy", int'(busy), 0);

        goto(415);
        for (int ch = 0; ch < CHANNELS; ch++) begin
            chk($sformatf("pending_ticks_ch%0d", ch), exp_q[ch].size(), 0);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
